// File: rtl/uart_rx_if.sv
// Peripheral bus bundle for uart_rx: register select, read/write strobes and data.
// Combinational wiring only; no latency, no backpressure (single-cycle strobes).
interface uart_rx_if;
    logic [2:0] addr;
    logic       ren;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       wen;
    logic [7:0] wdata;

    modport master (output addr, ren, wen, wdata, input rdata, rd_valid);
    modport slave  (input addr, ren, wen, wdata, output rdata, rd_valid);
endinterface

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO read over the peripheral bus.
// Reads return data one cycle after ren; a frame lands in the FIFO one cycle after its stop-bit sample.
// No backpressure on rx: a push into a full FIFO drops the byte and raises overrun.
module uart_rx #(
    parameter int CLK_DIV    = 104,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    uart_rx_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    state_t                state_q;
    logic [15:0]           div_q, div_eff, bit_div_q, cnt_q;
    logic [2:0]            idx_q;
    logic [7:0]            shift_q, push_dat_q;
    logic                  push_q, ferr_set_q, perr_set_q, par_bad_q;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ovr_q, ferr_q, perr;
    logic [7:0]            rdata_q, rd_mux, st_clr;
    logic                  rd_valid_q, empty, full, pop, push_ok, ovr_set, cnt_done, rx_fall;
    logic                  unused_bits;

    assign rx_fall  = rx_prev_q & ~rx_sync_q;
    assign div_eff  = (div_q < 16'd4) ? 16'd4 : div_q;
    assign cnt_done = (cnt_q <= 16'd1);
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign pop      = bus.ren && (bus.addr == 3'd0) && !empty;
    assign push_ok  = push_q && (!full || pop);
    assign ovr_set  = push_q && full && !pop;
    assign st_clr   = (bus.wen && bus.addr == 3'd1) ? bus.wdata : 8'h00;
    assign unused_bits = ^{st_clr[7:5], st_clr[1:0], par_bad_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Counter reaching 1 marks the sample point; START is loaded with half a bit to hit mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            bit_div_q  <= 16'(CLK_DIV);
            push_q     <= 1'b0;
            push_dat_q <= '0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            par_bad_q  <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            case (state_q)
                S_IDLE: if (rx_fall) begin
                    bit_div_q <= div_eff;
                    cnt_q     <= {1'b0, div_eff[15:1]};
                    state_q   <= S_START;
                end
                S_START: if (!cnt_done) cnt_q <= cnt_q - 16'd1;
                    else if (!rx_sync_q) begin
                        cnt_q   <= bit_div_q;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end else state_q <= S_IDLE;
                S_DATA: if (!cnt_done) cnt_q <= cnt_q - 16'd1;
                    else begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        cnt_q   <= bit_div_q;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else idx_q <= idx_q + 3'd1;
                    end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (!cnt_done) cnt_q <= cnt_q - 16'd1;
                    else begin
                        par_bad_q <= ^{shift_q, rx_sync_q};
                        cnt_q     <= bit_div_q;
                        state_q   <= S_STOP;
                    end
`endif
                S_STOP: if (!cnt_done) cnt_q <= cnt_q - 16'd1;
                    else if (rx_sync_q) begin
                        push_q     <= 1'b1;
                        push_dat_q <= shift_q;
                        perr_set_q <= par_bad_q;
                        state_q    <= S_IDLE;
                    end else begin
                        ferr_set_q <= 1'b1;
                        state_q    <= S_BREAK;
                    end
                S_BREAK: if (rx_sync_q) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_dat_q;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (bus.addr)
            3'd0: rd_mux = empty ? 8'h00 : mem[rd_ptr_q];
            3'd1: rd_mux = {3'b000, perr, ferr_q, ovr_q, full, !empty};
            3'd2: rd_mux = div_q[7:0];
            3'd3: rd_mux = div_q[15:8];
            3'd4: rd_mux = 8'(count_q);
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            div_q      <= 16'(CLK_DIV);
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
            ovr_q  <= ovr_set    | (ovr_q  & ~st_clr[2]);
            ferr_q <= ferr_set_q | (ferr_q & ~st_clr[3]);
            if (bus.wen && bus.addr == 3'd2) div_q[7:0]  <= bus.wdata;
            if (bus.wen && bus.addr == 3'd3) div_q[15:8] <= bus.wdata;
            rd_valid_q <= bus.ren;
            if (bus.ren) rdata_q <= rd_mux;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_set_q | (perr_q & ~st_clr[4]);
    end
    assign perr = perr_q;
`else
    logic unused_perr;
    assign unused_perr = ^{perr_set_q, st_clr[4]};
    assign perr = 1'b0;
`endif

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: serial frames in, bus reads out, FIFO contents tracked in a queue.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    uart_rx_if bus();

    uart_rx #(.CLK_DIV(104), .DEPTH_LOG2(3)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.wen = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.addr = a; bus.ren = 1'b1;
        @(negedge clk);
        bus.ren = 1'b0;
        check("rd_valid", {15'd0, bus.rd_valid}, 16'd1);
        d = bus.rdata;
    endtask

    task automatic read_data(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        bus_read(3'd0, rd);
        check(tag, {8'd0, rd}, {8'd0, e});
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
        bus_read(a, rd);
        check(tag, {8'd0, rd}, {8'd0, e});
    endtask

    task automatic drive_bit(input logic v, input int bc);
        rx = v;
        repeat (bc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stopv);
        @(negedge clk);
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b, bc);
`endif
        drive_bit(stopv, bc);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input int bc);
        send_frame(b, bc, 1'b1);
        if (exp_q.size() < 8) exp_q.push_back(b);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = 3'd0; bus.ren = 1'b0; bus.wen = 1'b0; bus.wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rdata", {8'd0, bus.rdata}, 16'h0000);
        check("rst_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reg("rst_status", 3'd1, 8'h00);
        check_reg("rst_level", 3'd4, 8'h00);
        check_reg("rst_div_lo", 3'd2, 8'h68);
        check_reg("rst_div_hi", 3'd3, 8'h00);
        check_reg("unmapped", 3'd6, 8'h00);

        // Single byte at 16 clocks per bit
        bus_write(3'd2, 8'd16);
        bus_write(3'd3, 8'd0);
        send_good(8'hA5, 16);
        check_reg("t1_level", 3'd4, 8'd1);
        check_reg("t1_status", 3'd1, 8'h01);
        read_data("t1_data");
        @(negedge clk);
        check("t1_rd_valid_low", {15'd0, bus.rd_valid}, 16'd0);
        check("t1_rdata_hold", {8'd0, bus.rdata}, 16'h00A5);
        check_reg("t1_level_after", 3'd4, 8'd0);

        // Fill past depth to force overrun
        for (int i = 0; i < 9; i++) send_good(8'(i), 16);
        check_reg("t2_status", 3'd1, 8'h07);
        check_reg("t2_level", 3'd4, 8'd8);
        for (int i = 0; i < 8; i++) read_data($sformatf("t2_data%0d", i));
        read_data("t2_empty_read");
        bus_write(3'd1, 8'h04);
        check_reg("t2_status_clr", 3'd1, 8'h00);

        // Framing error followed by a line break
        send_frame(8'h3C, 16, 1'b0);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_good(8'h11, 16);
        check_reg("t3_status", 3'd1, 8'h09);
        check_reg("t3_level", 3'd4, 8'd1);
        read_data("t3_data");
        bus_write(3'd1, 8'h08);
        check_reg("t3_status_clr", 3'd1, 8'h00);

        // Short glitch rejected as a false start
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_reg("t4_level", 3'd4, 8'd0);
        check_reg("t4_status", 3'd1, 8'h00);

        // 0x07 with a 0 in the slot after bit 7, then a 1
        @(negedge clk);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit((i < 3) ? 1'b1 : 1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        repeat (20) @(negedge clk);
`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        check_reg("t6_status", 3'd1, 8'h11);
        read_data("t6_data");
`else
        check_reg("t6_status", 3'd1, 8'h08);
        check_reg("t6_level", 3'd4, 8'd0);
`endif
        bus_write(3'd1, 8'h1C);
        check_reg("t6_status_clr", 3'd1, 8'h00);

        // Reset in the middle of bit 4
        check_reg("t5_div_pre", 3'd2, 8'd16);
        @(negedge clk);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b0, 16);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("t5_rst_rdata", {8'd0, bus.rdata}, 16'h0000);
        check("t5_rst_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reg("t5_div_lo", 3'd2, 8'h68);
        check_reg("t5_div_hi", 3'd3, 8'h00);
        check_reg("t5_level", 3'd4, 8'd0);
        check_reg("t5_status", 3'd1, 8'h00);
        send_good(8'h5A, 104);
        check_reg("t5_level_after", 3'd4, 8'd1);
        read_data("t5_data");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
